// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Central occupancy/control tracker for the MIPS pipeline latches. It keeps a
// valid bit and a tag for every inter-stage slot and applies the stall-bubble,
// partial-flush and halt-drain rules in one place. It also maintains the
// retirement and performance counters.
module pipeline_sequencer #(
    parameter int NUM_STAGES  = 5,
    parameter int TAG_WIDTH   = 32,
    parameter int STALL_STAGE = 1,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_issue_valid,
    input  logic [TAG_WIDTH-1:0]            i_issue_tag,
    output logic                            o_issue_ready,
    input  logic                            i_stall,
    input  logic                            i_flush,
    input  logic                            i_halt,
    output logic [NUM_STAGES-1:0]           o_stage_valid,
    output logic [NUM_STAGES*TAG_WIDTH-1:0] o_stage_tag,
    output logic                            o_retire_valid,
    output logic [TAG_WIDTH-1:0]            o_retire_tag,
    output logic                            o_halted,
    output logic [CNT_WIDTH-1:0]            o_cycle_count,
    output logic [CNT_WIDTH-1:0]            o_retire_count,
    output logic [CNT_WIDTH-1:0]            o_bubble_count,
    output logic [CNT_WIDTH-1:0]            o_flush_count
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                            state;
    state_t                            state_next;
    logic                              halted_q;

    logic [NUM_STAGES-1:0]             valid_q;
    logic [NUM_STAGES-1:0]             valid_d;
    logic [NUM_STAGES*TAG_WIDTH-1:0]   tag_q;
    logic [NUM_STAGES*TAG_WIDTH-1:0]   tag_d;

    logic [CNT_WIDTH-1:0]              cycle_q;
    logic [CNT_WIDTH-1:0]              retire_q;
    logic [CNT_WIDTH-1:0]              bubble_q;
    logic [CNT_WIDTH-1:0]              flush_q;

    logic                              active;
    logic                              issue_accept;
    logic                              pipe_empty;

    // Once halted everything is frozen, so "active" gates all slot and counter updates.
    assign active        = (state != ST_HALTED);
    assign pipe_empty    = (valid_q == '0);
    assign o_issue_ready = (state == ST_RUN) & ~i_stall & ~i_halt & ~i_flush;
    assign issue_accept  = i_issue_valid & o_issue_ready;

    // Slot next-values: default shift by one, then flush or stall overrides the low slots.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        if (active) begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                valid_d[k]                      = valid_q[k-1];
                tag_d[k*TAG_WIDTH +: TAG_WIDTH] = tag_q[(k-1)*TAG_WIDTH +: TAG_WIDTH];
            end
            if (i_flush) begin
                for (int k = 0; k < FLUSH_DEPTH; k++) begin
                    valid_d[k]                      = 1'b0;
                    tag_d[k*TAG_WIDTH +: TAG_WIDTH] = '0;
                end
            end else if (i_stall) begin
                for (int k = 0; k < STALL_STAGE; k++) begin
                    valid_d[k]                      = valid_q[k];
                    tag_d[k*TAG_WIDTH +: TAG_WIDTH] = tag_q[k*TAG_WIDTH +: TAG_WIDTH];
                end
                valid_d[STALL_STAGE]                          = 1'b0;
                tag_d[STALL_STAGE*TAG_WIDTH +: TAG_WIDTH]     = '0;
            end else begin
                valid_d[0]             = issue_accept;
                tag_d[0 +: TAG_WIDTH]  = issue_accept ? i_issue_tag : '0;
            end
        end
    end

    // Control FSM next state: a halt that coincides with a flush is wrong-path and ignored.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_RUN: begin
                if (i_halt && !i_flush) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_empty) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // State register plus a registered copy of the halted flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            halted_q <= 1'b0;
        end else begin
            state    <= state_next;
            halted_q <= (state_next == ST_HALTED);
        end
    end

    // Slot valid/tag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    // Performance counters; they wrap naturally and stop once halted.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q  <= '0;
            retire_q <= '0;
            bubble_q <= '0;
            flush_q  <= '0;
        end else if (active) begin
            cycle_q <= cycle_q + CNT_ONE;
            if (valid_q[NUM_STAGES-1]) begin
                retire_q <= retire_q + CNT_ONE;
            end
            if (i_flush) begin
                flush_q <= flush_q + CNT_ONE;
            end else if (i_stall) begin
                bubble_q <= bubble_q + CNT_ONE;
            end
        end
    end

    assign o_stage_valid  = valid_q;
    assign o_stage_tag    = tag_q;
    assign o_retire_valid = valid_q[NUM_STAGES-1];
    assign o_retire_tag   = tag_q[(NUM_STAGES-1)*TAG_WIDTH +: TAG_WIDTH];
    assign o_halted       = halted_q;
    assign o_cycle_count  = cycle_q;
    assign o_retire_count = retire_q;
    assign o_bubble_count = bubble_q;
    assign o_flush_count  = flush_q;

endmodule
